// File: rtl/bcd_seq_ctrl_if.sv
// Handshake and data bundle for the digit-serial BCD add/subtract sequencer.
// The requester drives start/op/a/b; the sequencer answers with busy/done/result.
interface bcd_seq_ctrl_if;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [19:0] result;
  logic        neg;
  logic        err;

  modport master (output start, op, a, b, input busy, done, result, neg, err);
  modport slave  (input start, op, a, b, output busy, done, result, neg, err);
endinterface

// File: rtl/bcd_seq_ctrl.sv
// Digit-serial 4-digit BCD adder/subtractor: one decimal-adjusted digit per cycle,
// with a second digit-serial pass that turns a negative difference into its magnitude.
//
// state | meaning
// IDLE  | waiting for start; holds last result/neg/err
// ADD   | a_i + b_i (or a_i + 9 - b_i) + carry, digit idx per cycle
// COMP  | 10's complement of the stored difference (negative result)
// DONE  | one-cycle done pulse, outputs valid
module bcd_seq_ctrl (
  input  logic           clk,
  input  logic           reset,
  bcd_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ADD, COMP, DONE} state_t;

  state_t      state, state_n;
  logic [1:0]  idx, idx_n;
  logic        carry, carry_n;
  logic        op_q, op_n;
  logic [15:0] a_q, a_n, b_q, b_n, acc, acc_n;
  logic [19:0] res_q, res_n;
  logic        neg_q, neg_n, err_q, err_n;

  logic [3:0]  dx, dy, dig;
  logic [4:0]  dsum;
  logic        dcarry;

  function automatic logic bcd_ok(input logic [15:0] v);
    bcd_ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if (v[i*4 +: 4] > 4'd9) bcd_ok = 1'b0;
  endfunction

  // Shared single-digit decimal adder; COMP reuses it as (9 - d) + carry.
  always_comb begin
    dx = a_q[3:0];
    dy = op_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
    if (state == COMP) begin
      dx = 4'd9 - acc[3:0];
      dy = 4'd0;
    end
    dsum   = {1'b0, dx} + {1'b0, dy} + {4'd0, carry};
    dcarry = (dsum > 5'd9);
    dig    = dcarry ? 4'(dsum - 5'd10) : dsum[3:0];
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    carry_n = carry;
    op_n    = op_q;
    a_n     = a_q;
    b_n     = b_q;
    acc_n   = acc;
    res_n   = res_q;
    neg_n   = neg_q;
    err_n   = err_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          a_n   = bus.a;
          b_n   = bus.b;
          op_n  = bus.op;
          idx_n = 2'd0;
          acc_n = 16'h0000;
          res_n = 20'h00000;
          neg_n = 1'b0;
          if (bcd_ok(bus.a) && bcd_ok(bus.b)) begin
            state_n = ADD;
            carry_n = bus.op;
            err_n   = 1'b0;
          end else begin
            state_n = DONE;
            carry_n = 1'b0;
            err_n   = 1'b1;
          end
        end
      end
      ADD: begin
        // Operands shift right so digit idx is always at [3:0]; sum digits enter acc from the top.
        acc_n   = {dig, acc[15:4]};
        a_n     = a_q >> 4;
        b_n     = b_q >> 4;
        carry_n = dcarry;
        idx_n   = idx + 2'd1;
        if (idx == 2'd3) begin
          if (!op_q) begin
            state_n = DONE;
            res_n   = {3'b000, dcarry, dig, acc[15:4]};
            carry_n = 1'b0;
          end else if (dcarry) begin
            state_n = DONE;
            res_n   = {4'h0, dig, acc[15:4]};
            neg_n   = 1'b0;
            carry_n = 1'b0;
          end else begin
            state_n = COMP;
            idx_n   = 2'd0;
            carry_n = 1'b1;
          end
        end
      end
      COMP: begin
        acc_n   = {dig, acc[15:4]};
        carry_n = dcarry;
        idx_n   = idx + 2'd1;
        if (idx == 2'd3) begin
          state_n = DONE;
          res_n   = {4'h0, dig, acc[15:4]};
          neg_n   = 1'b1;
          carry_n = 1'b0;
        end
      end
      DONE: begin
        state_n = IDLE;
        idx_n   = 2'd0;
        carry_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= 2'd0;
      carry <= 1'b0;
      op_q  <= 1'b0;
      a_q   <= 16'h0000;
      b_q   <= 16'h0000;
      acc   <= 16'h0000;
      res_q <= 20'h00000;
      neg_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      carry <= carry_n;
      op_q  <= op_n;
      a_q   <= a_n;
      b_q   <= b_n;
      acc   <= acc_n;
      res_q <= res_n;
      neg_q <= neg_n;
      err_q <= err_n;
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = res_q;
  assign bus.neg    = neg_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Self-checking bench for bcd_seq_ctrl: vector table through a scoreboard queue,
// plus hand sequences for mid-operation reset, start-while-busy and start-during-done.
module tb_bcd_seq_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  bcd_seq_ctrl_if bus();
  bcd_seq_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] result;
    logic        neg;
    logic        err;
    int          done_cyc;
  } exp_t;

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [19:0] res;
    logic        neg;
    logic        err;
    int          lat;
  } vec_t;

  exp_t sb[$];
  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, required no done", cyc);
      end else begin
        e = sb.pop_front();
        chk("result", {12'h0, bus.result}, {12'h0, e.result});
        chk("neg", {31'h0, bus.neg}, {31'h0, e.neg});
        chk("err", {31'h0, bus.err}, {31'h0, e.err});
        chk("done_cycle", cyc, e.done_cyc);
        chk("busy_at_done", {31'h0, bus.busy}, 32'h1);
      end
    end
  end

  task automatic push_exp(input logic [19:0] r, input logic n, input logic e, input int dc);
    exp_t x;
    x.result = r; x.neg = n; x.err = e; x.done_cyc = dc;
    sb.push_back(x);
  endtask

  task automatic drain(input int lim);
    int k = 0;
    while (sb.size() != 0 && k < lim) begin
      @(negedge clk); #1;
      k++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got %0d pending results, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = v.op; bus.a = v.a; bus.b = v.b;
    n = cyc;
    push_exp(v.res, v.neg, v.err, n + v.lat);
    @(negedge clk); #1;
    chk("busy_before_accept", {31'h0, bus.busy}, 32'h0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = ~v.op; bus.a = 16'($urandom); bus.b = 16'($urandom);
    @(negedge clk); #1;
    chk("busy_after_accept", {31'h0, bus.busy}, 32'h1);
    drain(20);
    @(negedge clk); #1;
    chk("done_single_cycle", {31'h0, bus.done}, 32'h0);
    chk("busy_back_idle", {31'h0, bus.busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vt[0]  = '{1'b0, 16'h1234, 16'h5678, 20'h06912, 1'b0, 1'b0, 5};
    vt[1]  = '{1'b0, 16'h9999, 16'h0001, 20'h10000, 1'b0, 1'b0, 5};
    vt[2]  = '{1'b1, 16'h5000, 16'h1234, 20'h03766, 1'b0, 1'b0, 5};
    vt[3]  = '{1'b1, 16'h1234, 16'h1234, 20'h00000, 1'b0, 1'b0, 5};
    vt[4]  = '{1'b1, 16'h1234, 16'h5000, 20'h03766, 1'b1, 1'b0, 9};
    vt[5]  = '{1'b0, 16'h12A4, 16'h0001, 20'h00000, 1'b0, 1'b1, 1};
    vt[6]  = '{1'b0, 16'h0000, 16'h0000, 20'h00000, 1'b0, 1'b0, 5};
    vt[7]  = '{1'b1, 16'h0000, 16'h0001, 20'h00001, 1'b1, 1'b0, 9};
    vt[8]  = '{1'b0, 16'h9999, 16'h9999, 20'h19998, 1'b0, 1'b0, 5};
    vt[9]  = '{1'b1, 16'h9999, 16'h0000, 20'h09999, 1'b0, 1'b0, 5};
    vt[10] = '{1'b1, 16'h0001, 16'h9999, 20'h09998, 1'b1, 1'b0, 9};
    vt[11] = '{1'b1, 16'h0000, 16'hF000, 20'h00000, 1'b0, 1'b1, 1};
    vt[12] = '{1'b0, 16'h0042, 16'h0058, 20'h00100, 1'b0, 1'b0, 5};

    bus.start = 1'b0; bus.op = 1'b0; bus.a = 16'h0; bus.b = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_done", {31'h0, bus.done}, 32'h0);
    chk("rst_result", {12'h0, bus.result}, 32'h0);
    chk("rst_neg_err", {30'h0, bus.neg, bus.err}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(vt[i]);

    // Reset while the adder is on digit 2: everything clears at once and no done follows.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'h1234; bus.b = 16'h5678;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_mid_add", {31'h0, bus.busy}, 32'h1);
    reset = 1'b1;
    #1;
    chk("async_rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("async_rst_done", {31'h0, bus.done}, 32'h0);
    chk("async_rst_result", {12'h0, bus.result}, 32'h0);
    chk("async_rst_neg_err", {30'h0, bus.neg, bus.err}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // First start after reset accepted; a second pulse while busy must be ignored.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'h0001; bus.b = 16'h0002;
    n = cyc;
    push_exp(20'h00003, 1'b0, 1'b0, n + 5);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 1'b1; bus.a = 16'h9999; bus.b = 16'h0001;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drain(20);
    repeat (8) @(negedge clk);

    // Start held across the DONE cycle is taken only in the following IDLE cycle.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'h0011; bus.b = 16'h0022;
    n = cyc;
    push_exp(20'h00033, 1'b0, 1'b0, n + 5);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = 16'h7777;
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'h0100; bus.b = 16'h0200;
    push_exp(20'h00300, 1'b0, 1'b0, n + 11);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drain(30);
    repeat (4) @(negedge clk);
    chk("hold_after_done", {12'h0, bus.result}, 32'h00300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd_seq_ctrl.md
BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

Interface
REQ-001 Parameters: none; the block is fixed at 4 BCD digits (16-bit operands, 20-bit result).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only when busy=0.
REQ-005 op  input  1  operation select: 0 = A+B, 1 = A-B; sampled with start.
REQ-006 a  input  16  operand A, 4 packed BCD digits, digit 0 in [3:0]; sampled with start.
REQ-007 b  input  16  operand B, same format as a; sampled with start.
REQ-008 busy  output  1  high from the cycle after an accepted start until the DONE cycle, inclusive.
REQ-009 done  output  1  single-cycle pulse marking result/neg/err valid.
REQ-010 result  output  20  BCD magnitude: [15:0] 4 digits, [16] carry digit, [19:17] always 0.
REQ-011 neg  output  1  1 = subtract result negative; result then holds the magnitude.
REQ-012 err  output  1  1 = an operand digit was >9 at start.

Function
REQ-013 The block SHALL be digit-serial: one single-digit BCD add (4-bit + 4-bit + carry -> 4-bit digit + carry, decimal-adjusted) per cycle, digit 0 first.
REQ-014 States SHALL be IDLE, ADD, COMP and DONE; a 2-bit digit index SHALL count 0..3 in ADD and in COMP.
REQ-015 IDLE: start=1 SHALL latch a, b and op; the transition depends on digit validity. Invalid digits (>9) in a or b go to DONE with err=1 and result=0. Valid digits go to ADD with index=0 and clear err and neg.
REQ-016 ADD, op=0: digit i = a_i + b_i + carry, with carry-in 0 at i=0.
REQ-017 ADD, op=1: digit i = a_i + (9 - b_i) + carry, with carry-in 1 at i=0, so the sum is the 10's complement of b added to a.
REQ-018 After ADD index 3, op=0 SHALL go to DONE with result[16] = final carry.
REQ-019 After ADD index 3, op=1 with final carry 1 SHALL go to DONE with neg=0 and result[16]=0.
REQ-020 After ADD index 3, op=1 with final carry 0 SHALL go to COMP with index=0.
REQ-021 COMP SHALL replace the stored digits with their 10's complement, digit-serially: d_i' = (9 - d_i) + carry, carry-in 1 at i=0, final carry discarded. After index 3 it SHALL go to DONE with neg=1 and result[16]=0.
REQ-022 Latency: if start is accepted at edge N, done=1 SHALL occur in the cycle after edge N+1 (err), N+5 (add, or subtract with non-negative result) or N+9 (negative subtract).
REQ-023 DONE SHALL last exactly one cycle, then IDLE; done SHALL be 0 in every other state.
REQ-024 result, neg and err SHALL hold their DONE values until the next accepted start. Intermediate digits SHALL NOT appear on result before done.
REQ-025 start while busy=1 SHALL be ignored, with no effect on the operation in progress or its latched operands.
REQ-026 start asserted during the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-027 An equal-operand subtract SHALL give result=0 and neg=0 (never "negative zero").
REQ-028 Input changes on a/b/op after acceptance SHALL NOT affect the result.

Reset
REQ-029 On reset=1 the block SHALL asynchronously force: state=IDLE, index=0, internal carry=0, busy=0, done=0, result=20'h00000, neg=0, err=0.
REQ-030 Reset asserted mid-operation (ADD or COMP) SHALL abort it; no done pulse SHALL follow, and the first start after release SHALL be accepted normally.

Verification
REQ-031 op=0, a=16'h1234, b=16'h5678 -> done at N+5, result=20'h06912, neg=0, err=0, busy high N+1..N+5.
REQ-032 op=0, a=16'h9999, b=16'h0001 -> done at N+5, result=20'h10000.
REQ-033 op=1, a=16'h5000, b=16'h1234 -> done at N+5, result=20'h03766, neg=0; then op=1, a=b=16'h1234 -> result=20'h00000, neg=0.
REQ-034 op=1, a=16'h1234, b=16'h5000 -> done at N+9, result=20'h03766, neg=1.
REQ-035 op=0, a=16'h12A4, b=16'h0001 -> done at N+1, err=1, result=20'h00000; next valid start clears err.
REQ-036 Reset mid-operation and start-while-busy cases:
- Reset during ADD index 2 -> all outputs 0 immediately, no done pulse.
- Then start (0001+0002), plus a second start pulse at N+2 -> single done at N+5, result=20'h00003.
